// File: rtl/distcalc_seq.sv
// Sequencer for the Euclidean distance datapath: clears the accumulator, feeds N chunks,
// runs the square root and hands the distance out on a valid/ready port.
module distcalc_seq #(
    parameter int VARWIDTH   = 32,
    parameter int CNTWIDTH   = 8,
    parameter int TMO_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNTWIDTH-1:0] nchunks,
    input  logic                chunk_valid,
    output logic                chunk_ready,
    output logic [CNTWIDTH-1:0] chunk_idx,
    output logic                en_pipe,
    output logic                en_acc,
    output logic                rst_acc,
    output logic                pre_acc,
    input  logic                rdy_acc,
    output logic                en_sqrt,
    output logic                rst_sqrt,
    input  logic                rdy_sqrt,
    input  logic [VARWIDTH-1:0] sqrt_val,
    output logic [VARWIDTH-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, ACCW, SQRST, SQRUN, OUT} state_t;

    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    state_t              state;
    logic [CNTWIDTH-1:0] nchunks_q;
    logic [TW-1:0]       timer;
    logic                xfer;
    logic                last_chunk;
    logic                tmo_hit;

    // The enables must coincide with the transfer itself, so they are the registered
    // chunk_ready gated by chunk_valid rather than a cycle-late copy of it.
    assign xfer       = chunk_ready & chunk_valid;
    assign en_pipe    = xfer;
    assign en_acc     = xfer;
    assign pre_acc    = xfer & (chunk_idx == '0);
    assign last_chunk = (chunk_idx == nchunks_q - CNTWIDTH'(1));
    assign tmo_hit    = (timer == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            nchunks_q    <= '0;
            timer        <= '0;
            chunk_ready  <= 1'b0;
            chunk_idx    <= '0;
            rst_acc      <= 1'b0;
            en_sqrt      <= 1'b0;
            rst_sqrt     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        chunk_idx <= '0;
                        if (nchunks != '0) begin
                            nchunks_q <= nchunks;
                            rst_acc   <= 1'b1;
                            state     <= CLEAR;
                        end else begin
                            result       <= '0;
                            result_valid <= 1'b1;
                            state        <= OUT;
                        end
                    end
                end
                CLEAR: begin
                    rst_acc     <= 1'b0;
                    chunk_idx   <= '0;
                    chunk_ready <= 1'b1;
                    state       <= FEED;
                end
                FEED: begin
                    if (chunk_valid) begin
                        chunk_ready <= 1'b0;
                        timer       <= '0;
                        state       <= ACCW;
                    end
                end
                ACCW: begin
                    if (rdy_acc) begin
                        timer <= '0;
                        if (last_chunk) begin
                            rst_sqrt <= 1'b1;
                            state    <= SQRST;
                        end else begin
                            chunk_idx   <= chunk_idx + CNTWIDTH'(1);
                            chunk_ready <= 1'b1;
                            state       <= FEED;
                        end
                    end else if (tmo_hit) begin
                        err          <= 1'b1;
                        result       <= '0;
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SQRST: begin
                    rst_sqrt <= 1'b0;
                    en_sqrt  <= 1'b1;
                    timer    <= '0;
                    state    <= SQRUN;
                end
                SQRUN: begin
                    if (rdy_sqrt) begin
                        en_sqrt      <= 1'b0;
                        result       <= sqrt_val;
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end else if (tmo_hit) begin
                        en_sqrt      <= 1'b0;
                        err          <= 1'b1;
                        result       <= '0;
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                OUT: begin
                    // Returning through IDLE enforces the one-cycle gap between jobs.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_distcalc_seq.sv
// Directed + randomized bench for distcalc_seq: a behavioural datapath responder answers
// en_acc/en_sqrt after chosen latencies and per-job expectations come from the job rules.
module tb_distcalc_seq;

    localparam int VW  = 32;
    localparam int CW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] nchunks;
    logic          chunk_valid;
    logic          chunk_ready;
    logic [CW-1:0] chunk_idx;
    logic          en_pipe, en_acc, rst_acc, pre_acc, rdy_acc;
    logic          en_sqrt, rst_sqrt, rdy_sqrt;
    logic [VW-1:0] sqrt_val;
    logic [VW-1:0] result;
    logic          result_valid, result_ready, busy, err;

    distcalc_seq #(.VARWIDTH(VW), .CNTWIDTH(CW), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .nchunks(nchunks),
        .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .chunk_idx(chunk_idx),
        .en_pipe(en_pipe), .en_acc(en_acc), .rst_acc(rst_acc), .pre_acc(pre_acc),
        .rdy_acc(rdy_acc), .en_sqrt(en_sqrt), .rst_sqrt(rst_sqrt), .rdy_sqrt(rdy_sqrt),
        .sqrt_val(sqrt_val), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder knobs (written by the main sequence only)
    int acc_lat = 1, sq_lat = 1;
    bit acc_never = 1'b0;

    // Responder/monitor state (written by the monitor only)
    int n_xfer = 0, n_en_acc = 0, n_en_pipe = 0, n_pre = 0, n_pre_nz = 0;
    int n_rst_acc = 0, n_rst_sqrt = 0, n_sq_rise = 0;
    int acc_due = -1, sq_due = -1;
    bit sq_prev = 1'b0;
    int idx_q[$];

    initial begin
        rdy_acc  = 1'b0;
        rdy_sqrt = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rdy_acc  = 1'b0;
                rdy_sqrt = 1'b0;
                sq_prev  = 1'b0;
            end else begin
                if (en_acc) begin n_en_acc++; acc_due = cyc + acc_lat; end
                if (en_pipe) n_en_pipe++;
                if (chunk_valid && chunk_ready) begin n_xfer++; idx_q.push_back(int'(chunk_idx)); end
                if (pre_acc) begin n_pre++; if (chunk_idx != '0) n_pre_nz++; end
                if (rst_acc) n_rst_acc++;
                if (rst_sqrt) n_rst_sqrt++;
                if (en_sqrt && !sq_prev) begin n_sq_rise++; sq_due = cyc + sq_lat; end
                sq_prev  = en_sqrt;
                rdy_acc  = !acc_never && (cyc == acc_due);
                rdy_sqrt = (cyc == sq_due);
            end
        end
    end

    int checks = 0, failures = 0;
    int c0;
    logic [VW-1:0] exp_sqrt;
    int s_xfer, s_en_acc, s_en_pipe, s_pre, s_pre_nz, s_rst_acc, s_rst_sqrt, s_sq_rise, s_q;
    int rn, ra, rs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_xfer = n_xfer; s_en_acc = n_en_acc; s_en_pipe = n_en_pipe; s_pre = n_pre;
        s_pre_nz = n_pre_nz; s_rst_acc = n_rst_acc; s_rst_sqrt = n_rst_sqrt;
        s_sq_rise = n_sq_rise; s_q = idx_q.size();
    endtask

    task automatic check_zero_outs(input string tag);
        check(tag, {chunk_ready, en_pipe, en_acc, rst_acc, pre_acc, en_sqrt, rst_sqrt,
                    result_valid, busy, err, chunk_idx, result}, 64'd0);
    endtask

    // Present a job; the cycle in which start is sampled is remembered in c0.
    task automatic launch(input int n, input int a, input int s);
        @(negedge clk);
        acc_lat   = a;
        sq_lat    = s;
        acc_never = 1'b0;
        sqrt_val  = $urandom;
        exp_sqrt  = sqrt_val;
        start     = 1'b1;
        nchunks   = CW'(n);
        c0        = cyc;
        snap();
    endtask

    task automatic wait_rv(input int mode, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = 1'b0;
            case (mode)
                0:       chunk_valid = 1'b1;
                1:       chunk_valid = cyc[0];
                default: chunk_valid = 1'($urandom_range(0, 1));
            endcase
            if (result_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic finish(input string tag, input int n, input int a, input int s,
                          input int mode, input bit lat);
        bit ok;
        int mism;
        bit nz;
        nz = (n != 0);
        wait_rv(mode, ok);
        check({tag, "_rv"}, 64'(ok), 64'd1);
        if (!ok) return;
        if (lat) check({tag, "_lat"}, 64'(cyc), nz ? 64'(c0 + 1 + 1 + n * (1 + a) + 1 + (s + 1)) : 64'(c0 + 1));
        check({tag, "_result"}, 64'(result), nz ? 64'(exp_sqrt) : 64'd0);
        check({tag, "_err_busy"}, {err, busy}, 64'b01);
        check({tag, "_xfer"}, 64'(n_xfer - s_xfer), 64'(n));
        check({tag, "_en_acc"}, 64'(n_en_acc - s_en_acc), 64'(n));
        check({tag, "_en_pipe"}, 64'(n_en_pipe - s_en_pipe), 64'(n));
        check({tag, "_pre"}, 64'(n_pre - s_pre), 64'(nz));
        check({tag, "_pre_nz"}, 64'(n_pre_nz - s_pre_nz), 64'd0);
        check({tag, "_rst_acc"}, 64'(n_rst_acc - s_rst_acc), 64'(nz));
        check({tag, "_rst_sqrt"}, 64'(n_rst_sqrt - s_rst_sqrt), 64'(nz));
        check({tag, "_en_sqrt"}, 64'(n_sq_rise - s_sq_rise), 64'(nz));
        mism = 0;
        for (int k = 0; k < n; k++)
            if (s_q + k >= idx_q.size() || idx_q[s_q + k] != k) mism++;
        check({tag, "_idx_seq"}, 64'(mism), 64'd0);
    endtask

    task automatic release_res(input string tag);
        @(negedge clk);
        start        = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({tag, "_released"}, {result_valid, busy}, 64'd0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; nchunks = '0; chunk_valid = 1'b0;
        result_ready = 1'b0; sqrt_val = '0;
        repeat (3) @(negedge clk);
        check_zero_outs("reset_outs");
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {busy, chunk_ready, result_valid}, 64'd0);

        // Single chunk, A=2, S=3, latency from the job formula
        launch(1, 2, 3);
        finish("single", 1, 2, 3, 0, 1'b1);
        release_res("single");

        // Four chunks with chunk_valid toggling
        launch(4, 1, 2);
        finish("toggle4", 4, 1, 2, 1, 1'b0);
        release_res("toggle4");

        // Empty job: no datapath activity, result next cycle
        launch(0, 1, 1);
        finish("zero", 0, 1, 1, 0, 1'b1);
        release_res("zero");

        // Accumulator never answers: timeout after TMO wait cycles
        launch(3, 1, 1);
        acc_never = 1'b1;
        wait_rv(0, ok);
        check("tmo_rv", 64'(ok), 64'd1);
        check("tmo_lat", 64'(cyc), 64'(c0 + 1 + 1 + 1 + TMO));
        check("tmo_err_res", {err, result}, {1'b1, 32'd0});
        check("tmo_no_sqrt", 64'(n_sq_rise - s_sq_rise + n_rst_sqrt - s_rst_sqrt), 64'd0);
        check("tmo_xfer", 64'(n_xfer - s_xfer), 64'd1);
        @(negedge clk);
        check("tmo_err_sticky", {err, result_valid}, 64'b11);
        release_res("tmo");
        check("tmo_err_held_idle", 64'(err), 64'd1);
        launch(0, 1, 1);
        finish("err_clear", 0, 1, 1, 0, 1'b0);
        release_res("err_clear");

        // Asynchronous reset while the square root is running
        launch(2, 1, 12);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            chunk_valid = 1'b1;
            if (en_sqrt) begin ok = 1'b1; break; end
        end
        check("sqrun_reached", 64'(ok), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outs("async_reset_outs");
        @(negedge clk);
        rst = 1'b0;
        launch(3, 2, 2);
        finish("after_reset", 3, 2, 2, 0, 1'b1);
        release_res("after_reset");

        // Result held while result_ready stays low and start stays high
        launch(2, 1, 2);
        finish("hold", 2, 1, 2, 0, 1'b1);
        snap();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b1;
            check("hold_stable", {result_valid, busy, result}, {1'b1, 1'b1, exp_sqrt});
        end
        check("hold_no_new_job", 64'(n_rst_acc - s_rst_acc), 64'd0);
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        c0 = cyc;
        snap();
        check("hold_gap_idle", {busy, result_valid, rst_acc}, 64'd0);
        @(negedge clk);
        check("hold_new_accept", {busy, rst_acc}, 64'b11);
        finish("hold_next", 2, 1, 2, 0, 1'b0);
        release_res("hold_next");

        // Largest chunk count must finish without index wrap
        launch(255, 1, 1);
        finish("max", 255, 1, 1, 0, 1'b1);
        release_res("max");

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            rn = $urandom_range(1, 9);
            ra = $urandom_range(1, 6);
            rs = $urandom_range(1, 9);
            launch(rn, ra, rs);
            finish("rand", rn, ra, rs, (j < 2) ? 0 : 2, (j < 2));
            release_res("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
